// File: rtl/gate_sequencer.sv
// Walks a netlist gate by gate for a number of circuit cycles, presenting each
// gate descriptor to the garbler through a valid/ready handshake.
module gate_sequencer #(
    parameter int S  = 20,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_cycles,
    output logic          nl_start,
    input  logic          nl_done,
    input  logic [S-1:0]  nl_gate_size,
    output logic [S-1:0]  nl_gid,
    input  logic [S-1:0]  nl_in0,
    input  logic [S-1:0]  nl_in1,
    input  logic          nl_in0F,
    input  logic          nl_in1F,
    input  logic          nl_is_output,
    input  logic [3:0]    nl_g_logic,
    output logic          g_valid,
    input  logic          g_ready,
    output logic [S-1:0]  g_gid,
    output logic [S-1:0]  g_in0,
    output logic [S-1:0]  g_in1,
    output logic          g_in0F,
    output logic          g_in1F,
    output logic          g_is_output,
    output logic [3:0]    g_logic,
    output logic [CW-1:0] g_cycle,
    output logic          g_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        ISSUE = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [S-1:0]  GID_ONE = {{(S-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CYC_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [S-1:0]  gid;
    logic [S-1:0]  gsize;
    logic [CW-1:0] cycle;
    logic [CW-1:0] ncyc;
    logic          hs;
    logic          last_gid;
    logic          last_cyc;

    // gsize and ncyc are never zero once used, so subtracting one cannot wrap
    assign hs       = g_valid & g_ready;
    assign last_gid = (gid == (gsize - GID_ONE));
    assign last_cyc = (cycle == (ncyc - CYC_ONE));
    assign nl_gid   = gid;
    assign g_cycle  = cycle;
    assign busy     = (state != IDLE) && (state != DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = HDR;
                else       state_nxt = state;
            end
            HDR: begin
                if (!nl_done)                         state_nxt = HDR;
                else if (nl_gate_size == {S{1'b0}})   state_nxt = DONE;
                else                                  state_nxt = FETCH;
            end
            FETCH: state_nxt = ISSUE;
            ISSUE: begin
                if (!hs)          state_nxt = ISSUE;
                else if (last_gid) state_nxt = NEXT;
                else              state_nxt = FETCH;
            end
            NEXT: begin
                if (last_cyc) state_nxt = DONE;
                else          state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, latched header values and the registered descriptor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nl_start    <= 1'b0;
            gid         <= {S{1'b0}};
            gsize       <= {S{1'b0}};
            cycle       <= {CW{1'b0}};
            ncyc        <= {CW{1'b0}};
            done        <= 1'b0;
            g_valid     <= 1'b0;
            g_gid       <= {S{1'b0}};
            g_in0       <= {S{1'b0}};
            g_in1       <= {S{1'b0}};
            g_in0F      <= 1'b0;
            g_in1F      <= 1'b0;
            g_is_output <= 1'b0;
            g_logic     <= 4'd0;
            g_last      <= 1'b0;
        end else begin
            nl_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        nl_start <= 1'b1;
                        ncyc     <= (num_cycles == {CW{1'b0}}) ? CYC_ONE : num_cycles;
                        gid      <= {S{1'b0}};
                        cycle    <= {CW{1'b0}};
                        done     <= 1'b0;
                    end
                end
                HDR: begin
                    if (nl_done) begin
                        gsize <= nl_gate_size;
                        if (nl_gate_size == {S{1'b0}}) done <= 1'b1;
                    end
                end
                FETCH: begin
                    g_valid     <= 1'b1;
                    g_gid       <= gid;
                    g_in0       <= nl_in0;
                    g_in1       <= nl_in1;
                    g_in0F      <= nl_in0F;
                    g_in1F      <= nl_in1F;
                    g_is_output <= nl_is_output;
                    g_logic     <= nl_g_logic;
                    g_last      <= last_gid && last_cyc;
                end
                ISSUE: begin
                    if (hs) begin
                        g_valid <= 1'b0;
                        if (!last_gid) gid <= gid + GID_ONE;
                    end
                end
                NEXT: begin
                    if (last_cyc) begin
                        done <= 1'b1;
                    end else begin
                        cycle <= cycle + CYC_ONE;
                        gid   <= {S{1'b0}};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: directed scenario table, reset/stall sequences and
// randomized transactions checked against an expected issue list.
module tb_gate_sequencer;
    localparam int S  = 20;
    localparam int CW = 16;

    logic          clk, rst_n, start, nl_start, nl_done, g_valid, g_ready;
    logic [CW-1:0] num_cycles, g_cycle;
    logic [S-1:0]  nl_gate_size, nl_gid, nl_in0, nl_in1, g_gid, g_in0, g_in1;
    logic          nl_in0F, nl_in1F, nl_is_output, g_in0F, g_in1F, g_is_output;
    logic [3:0]    nl_g_logic, g_logic;
    logic          g_last, busy, done;

    int errors = 0;
    int checks = 0;

    gate_sequencer #(.S(S), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
        .nl_start(nl_start), .nl_done(nl_done), .nl_gate_size(nl_gate_size),
        .nl_gid(nl_gid), .nl_in0(nl_in0), .nl_in1(nl_in1), .nl_in0F(nl_in0F),
        .nl_in1F(nl_in1F), .nl_is_output(nl_is_output), .nl_g_logic(nl_g_logic),
        .g_valid(g_valid), .g_ready(g_ready), .g_gid(g_gid), .g_in0(g_in0),
        .g_in1(g_in1), .g_in0F(g_in0F), .g_in1F(g_in1F), .g_is_output(g_is_output),
        .g_logic(g_logic), .g_cycle(g_cycle), .g_last(g_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Netlist contents: each gate's descriptor is a fixed function of its index
    function automatic logic [S-1:0] d_in0(input logic [S-1:0] g);
        return g * 20'd7 + 20'd3;
    endfunction
    function automatic logic [S-1:0] d_in1(input logic [S-1:0] g);
        return g ^ 20'h5A5A5;
    endfunction
    function automatic logic [3:0] d_logic(input logic [S-1:0] g);
        return g[3:0] ^ 4'h9;
    endfunction

    assign nl_in0       = d_in0(nl_gid);
    assign nl_in1       = d_in1(nl_gid);
    assign nl_in0F      = nl_gid[0];
    assign nl_in1F      = nl_gid[1];
    assign nl_is_output = nl_gid[2];
    assign nl_g_logic   = d_logic(nl_gid);

    typedef struct {
        int gs;
        int nc;
        int hold;
        bit noisy;
        int edges;
    } vec_t;

    typedef struct {
        int c;
        int g;
        bit last;
    } issue_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_vec(input issue_t it);
        logic [S-1:0] g;
        g = S'(it.g);
        return {44'd0, g, CW'(it.c), d_in0(g), d_in1(g), g[0], g[1], g[2], d_logic(g), it.last};
    endfunction

    function automatic logic [127:0] act_vec();
        return {44'd0, g_gid, g_cycle, g_in0, g_in1, g_in0F, g_in1F, g_is_output, g_logic, g_last};
    endfunction

    function automatic logic [127:0] all_outs();
        return {18'd0, nl_start, nl_gid, g_valid, g_gid, g_in0, g_in1, g_in0F, g_in1F,
                g_is_output, g_logic, g_cycle, g_last, busy, done};
    endfunction

    // One full transaction, entered and left on a falling edge
    task automatic run_txn(input int gs, input int nc, input int rdy_pct, input int hold,
                           input bit noisy, input bit rdly, input int exp_edges);
        issue_t q[$];
        issue_t it;
        int ncc, edges, starts, done_edge, dly, hold_left;
        bit pending;
        ncc = (nc == 0) ? 1 : nc;
        for (int c = 0; c < ncc; c++)
            for (int g = 0; g < gs; g++) begin
                it.c = c; it.g = g; it.last = (c == ncc - 1) && (g == gs - 1);
                q.push_back(it);
            end
        num_cycles = CW'(nc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1; starts = 0; done_edge = -1; dly = 0; pending = 1'b0; hold_left = hold;
        while (edges < 2000) begin
            if (done) begin
                done_edge = edges;
                break;
            end
            if (nl_start) begin
                starts++;
                pending = 1'b1;
                dly = rdly ? $urandom_range(0, 3) : 0;
            end
            if (pending && dly == 0) begin
                nl_done = 1'b1; nl_gate_size = S'(gs); pending = 1'b0;
            end else begin
                nl_done = 1'b0; nl_gate_size = 20'($urandom);
                if (pending) dly--;
            end
            if (g_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_issue", act_vec(), 128'd0);
                    g_ready = 1'b1;
                end else begin
                    chk("issue", act_vec(), exp_vec(q[0]));
                    if (hold_left > 0) begin
                        g_ready = 1'b0; hold_left--;
                    end else begin
                        g_ready = ($urandom_range(0, 99) < rdy_pct);
                    end
                    if (g_ready) void'(q.pop_front());
                end
            end else begin
                g_ready = 1'($urandom);
            end
            start = noisy && busy && 1'($urandom);
            @(negedge clk);
            edges++;
        end
        start = 1'b0; nl_done = 1'b0; g_ready = 1'b0;
        chk("done_reached", 128'(done_edge >= 0), 128'd1);
        chk("issues_left", 128'(q.size()), 128'd0);
        chk("nl_start_count", 128'(starts), 128'd1);
        chk("idle_at_done", {126'd0, busy, g_valid}, 128'd0);
        if (exp_edges >= 0) chk("done_latency", 128'(done_edge), 128'(exp_edges));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{gs: 3, nc: 1, hold: 0, noisy: 1'b0, edges: 9};
        tbl[1] = '{gs: 2, nc: 3, hold: 0, noisy: 1'b1, edges: 17};
        tbl[2] = '{gs: 0, nc: 5, hold: 0, noisy: 1'b0, edges: 2};
        tbl[3] = '{gs: 1, nc: 0, hold: 0, noisy: 1'b0, edges: 5};
        tbl[4] = '{gs: 1, nc: 1, hold: 5, noisy: 1'b0, edges: 10};
        tbl[5] = '{gs: 4, nc: 2, hold: 0, noisy: 1'b1, edges: 20};

        rst_n = 1'b0; start = 1'b0; num_cycles = '0; nl_done = 1'b0;
        nl_gate_size = '0; g_ready = 1'b0;
        #1;
        chk("reset_state", all_outs(), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 128'd0);

        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].gs, tbl[i].nc, 100, tbl[i].hold, tbl[i].noisy, 1'b0, tbl[i].edges);

        // Reset while a descriptor waits on the garbler
        num_cycles = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; nl_gate_size = 20'd3; nl_done = 1'b1;
        @(negedge clk);
        nl_done = 1'b0; g_ready = 1'b0;
        for (int k = 0; k < 10 && !g_valid; k++) @(negedge clk);
        chk("valid_before_reset", 128'(g_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_clears", all_outs(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g_ready = 1'b1;
            @(negedge clk);
            chk("quiet_after_reset", {124'd0, g_valid, done, busy, nl_start}, 128'd0);
        end
        g_ready = 1'b0;
        run_txn(3, 2, 100, 0, 1'b0, 1'b0, 2 + 2 * 7);

        for (int i = 0; i < 30; i++)
            run_txn($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(30, 100),
                    $urandom_range(0, 2), 1'($urandom), 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
